alu_sched: RTL and testbench

ALU_SCHED -- requirements
Module: alu_sched

---
 rtl/alu_sched.sv | 71 +++++++
 tb/tb_alu_sched.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/alu_sched.sv
// alu_sched: round-robin scheduler sharing one external combinational ALU among three requesters
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/req_ready      per-requester handshake (req_ready one-hot or zero)
//   req_x/req_y/req_f        packed per-requester operands (4b) and opcode (2b)
//   alu_x/alu_y/alu_f        registered operands/opcode to the shared ALU
//   alu_xy                   ALU result, captured one cycle after accept
//   rsp_valid/rsp_ready      response handshake with rsp_data and rsp_id
//   ops_done                 modulo-256 count of completed responses
module alu_sched (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req_valid,
  output logic [2:0]  req_ready,
  input  logic [11:0] req_x,
  input  logic [11:0] req_y,
  input  logic [5:0]  req_f,
  output logic [3:0]  alu_x,
  output logic [3:0]  alu_y,
  output logic [1:0]  alu_f,
  input  logic [3:0]  alu_xy,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [3:0]  rsp_data,
  output logic [1:0]  rsp_id,
  output logic [7:0]  ops_done
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state_q, state_d;
  logic [1:0] last_q, c0, c1, c2, win;
  logic accept;
  function automatic logic [1:0] inc3(input logic [1:0] v);
    return v == 2'd2 ? 2'd0 : v + 2'd1;
  endfunction
  // Candidates in priority order, starting just after the last grant.
  always_comb begin
    c0 = inc3(last_q);
    c1 = inc3(c0);
    c2 = inc3(c1);
    win = req_valid[c0] ? c0 : req_valid[c1] ? c1 : c2;
    req_ready = (state_q == IDLE && |req_valid) ? 3'b001 << win : 3'b000;
    accept = |(req_valid & req_ready);
    state_d = state_q == IDLE ? (accept ? EXEC : IDLE) :
              state_q == EXEC ? RESP :
              (rsp_ready ? IDLE : RESP);
  end
  assign rsp_valid = state_q == RESP;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      last_q   <= 2'd2;
      alu_x    <= '0;
      alu_y    <= '0;
      alu_f    <= '0;
      rsp_data <= '0;
      rsp_id   <= '0;
      ops_done <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        alu_x  <= req_x[{win, 2'b00} +: 4];
        alu_y  <= req_y[{win, 2'b00} +: 4];
        alu_f  <= req_f[{win, 1'b0} +: 2];
        rsp_id <= win;
        last_q <= win;
      end
      if (state_q == EXEC) rsp_data <= alu_xy;
      if (state_q == RESP && rsp_ready) ops_done <= ops_done + 8'd1;
    end
  end
endmodule

// File: tb/tb_alu_sched.sv
// tb_alu_sched: directed self-checking bench for alu_sched with a behavioural shared ALU
module tb_alu_sched;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  req_valid = '0;
  logic [2:0]  req_ready;
  logic [11:0] req_x = '0, req_y = '0;
  logic [5:0]  req_f = '0;
  logic [3:0]  alu_x, alu_y, alu_xy;
  logic [1:0]  alu_f;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [3:0]  rsp_data;
  logic [1:0]  rsp_id;
  logic [7:0]  ops_done;
  int checks = 0, failures = 0;
  logic [7:0] exp_ops = 0;

  always #5 clk = ~clk;

  always_comb alu_xy = alu_f == 2'd0 ? alu_x + alu_y :
                       alu_f == 2'd1 ? alu_x - alu_y :
                       alu_f == 2'd2 ? {alu_x[2:0], 1'b0} : 4'd0;

  alu_sched dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_f(req_f),
    .alu_x(alu_x), .alu_y(alu_y), .alu_f(alu_f), .alu_xy(alu_xy),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .ops_done(ops_done)
  );

  task automatic test_reset();
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got %0h want 0", rsp_valid); end
    checks++; if (rsp_data !== 4'd0) begin failures++; $display("FAIL reset_rsp_data got %0h want 0", rsp_data); end
    checks++; if (rsp_id !== 2'd0) begin failures++; $display("FAIL reset_rsp_id got %0h want 0", rsp_id); end
    checks++; if ({alu_x, alu_y, alu_f} !== 10'd0) begin failures++; $display("FAIL reset_alu got %0h want 0", {alu_x, alu_y, alu_f}); end
    checks++; if (ops_done !== 8'd0) begin failures++; $display("FAIL reset_ops_done got %0h want 0", ops_done); end
    checks++; if (req_ready !== 3'b000) begin failures++; $display("FAIL reset_req_ready got %0b want 000", req_ready); end
    @(negedge clk);
    rst = 1'b0;
    exp_ops = 0;
  endtask

  task automatic test_single_ops();
    int id[4] = '{0, 1, 2, 1};
    logic [3:0] vx[4] = '{4'd3, 4'd2, 4'd9, 4'd7};
    logic [3:0] vy[4] = '{4'd5, 4'd5, 4'd0, 4'd4};
    logic [1:0] vf[4] = '{2'd0, 2'd1, 2'd2, 2'd3};
    logic [3:0] ve[4] = '{4'h8, 4'hD, 4'h2, 4'h0};
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      req_x = '0; req_y = '0; req_f = '0;
      req_x[id[k]*4 +: 4] = vx[k];
      req_y[id[k]*4 +: 4] = vy[k];
      req_f[id[k]*2 +: 2] = vf[k];
      req_valid = 3'b001 << id[k];
      #1;
      checks++; if (req_ready !== (3'b001 << id[k])) begin failures++; $display("FAIL single_req_ready[%0d] got %0b want %0b", k, req_ready, 3'b001 << id[k]); end
      @(negedge clk);
      req_valid = '0;
      checks++; if ({alu_x, alu_y, alu_f} !== {vx[k], vy[k], vf[k]}) begin failures++; $display("FAIL single_alu_regs[%0d] got %0h want %0h", k, {alu_x, alu_y, alu_f}, {vx[k], vy[k], vf[k]}); end
      checks++; if ({rsp_valid, req_ready} !== 4'b0000) begin failures++; $display("FAIL single_exec_idle_outputs[%0d] got %0b want 0000", k, {rsp_valid, req_ready}); end
      @(negedge clk);
      checks++; if ({rsp_valid, rsp_data, rsp_id} !== {1'b1, ve[k], 2'(id[k])}) begin failures++; $display("FAIL single_rsp[%0d] got %0h want %0h", k, {rsp_valid, rsp_data, rsp_id}, {1'b1, ve[k], 2'(id[k])}); end
      @(negedge clk);
      exp_ops++;
      checks++; if ({rsp_valid, ops_done} !== {1'b0, exp_ops}) begin failures++; $display("FAIL single_done[%0d] got %0h want %0h", k, {rsp_valid, ops_done}, {1'b0, exp_ops}); end
    end
  endtask

  task automatic test_round_robin();
    int ord[5] = '{0, 1, 2, 0, 1};
    logic [3:0] ve[3] = '{4'h2, 4'h5, 4'hC};
    rst = 1'b1;
    req_x = {4'd6, 4'd7, 4'd1};
    req_y = {4'd0, 4'd2, 4'd1};
    req_f = {2'd2, 2'd1, 2'd0};
    req_valid = 3'b111;
    rsp_ready = 1'b1;
    #1 rst = 1'b0;
    exp_ops = 0;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if (req_ready !== (3'b001 << ord[k])) begin failures++; $display("FAIL rr_grant[%0d] got %0b want %0b", k, req_ready, 3'b001 << ord[k]); end
      @(negedge clk);
      checks++; if (req_ready !== 3'b000) begin failures++; $display("FAIL rr_exec_ready[%0d] got %0b want 000", k, req_ready); end
      @(negedge clk);
      checks++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'(ord[k]), ve[ord[k]]}) begin failures++; $display("FAIL rr_rsp[%0d] got %0h want %0h", k, {rsp_valid, rsp_id, rsp_data}, {1'b1, 2'(ord[k]), ve[ord[k]]}); end
      @(negedge clk);
      exp_ops++;
    end
    req_valid = '0;
    checks++; if (ops_done !== exp_ops) begin failures++; $display("FAIL rr_ops_done got %0d want %0d", ops_done, exp_ops); end
  endtask

  task automatic test_backpressure();
    req_x = {4'd0, 4'd2, 4'd0};
    req_y = {4'd0, 4'd5, 4'd0};
    req_f = {2'd0, 2'd1, 2'd0};
    req_valid = 3'b010;
    rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 3'b001;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      checks++; if ({rsp_valid, rsp_data, rsp_id, req_ready} !== {1'b1, 4'hD, 2'd1, 3'b000}) begin failures++; $display("FAIL bp_hold[%0d] got %0h want %0h", k, {rsp_valid, rsp_data, rsp_id, req_ready}, {1'b1, 4'hD, 2'd1, 3'b000}); end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    exp_ops++;
    checks++; if ({rsp_valid, ops_done, req_ready} !== {1'b0, exp_ops, 3'b001}) begin failures++; $display("FAIL bp_release got %0h want %0h", {rsp_valid, ops_done, req_ready}, {1'b0, exp_ops, 3'b001}); end
    req_valid = '0;
  endtask

  task automatic test_reset_exec();
    req_x = {4'd9, 4'd0, 4'd3};
    req_y = {4'd0, 4'd0, 4'd5};
    req_f = {2'd2, 2'd0, 2'd0};
    req_valid = 3'b001;
    rsp_ready = 1'b1;
    @(negedge clk);
    req_valid = '0;
    rst = 1'b1;
    #1;
    checks++; if ({rsp_valid, rsp_data, rsp_id, ops_done} !== 15'd0) begin failures++; $display("FAIL rstexec_rsp got %0h want 0", {rsp_valid, rsp_data, rsp_id, ops_done}); end
    checks++; if ({alu_x, alu_y, alu_f, req_ready} !== 13'd0) begin failures++; $display("FAIL rstexec_alu got %0h want 0", {alu_x, alu_y, alu_f, req_ready}); end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rstexec_no_rsp[%0d] got %0b want 0", k, rsp_valid); end
    end
    rst = 1'b0;
    exp_ops = 0;
    req_valid = 3'b100;
    @(negedge clk);
    req_valid = '0;
    checks++; if ({alu_x, alu_f, req_ready} !== {4'd9, 2'd2, 3'b000}) begin failures++; $display("FAIL rstexec_first_accept got %0h want %0h", {alu_x, alu_f, req_ready}, {4'd9, 2'd2, 3'b000}); end
    @(negedge clk);
    checks++; if ({rsp_valid, rsp_data, rsp_id} !== {1'b1, 4'h2, 2'd2}) begin failures++; $display("FAIL rstexec_rsp_after got %0h want %0h", {rsp_valid, rsp_data, rsp_id}, {1'b1, 4'h2, 2'd2}); end
    @(negedge clk);
    exp_ops++;
    checks++; if (ops_done !== exp_ops) begin failures++; $display("FAIL rstexec_ops_done got %0d want %0d", ops_done, exp_ops); end
  endtask

  task automatic test_wrap();
    rst = 1'b1;
    req_x = 12'h001; req_y = 12'h001; req_f = '0;
    req_valid = 3'b001;
    rsp_ready = 1'b1;
    #1 rst = 1'b0;
    repeat (255 * 3) @(negedge clk);
    checks++; if (ops_done !== 8'd255) begin failures++; $display("FAIL wrap_255 got %0d want 255", ops_done); end
    repeat (3) @(negedge clk);
    checks++; if (ops_done !== 8'd0) begin failures++; $display("FAIL wrap_256 got %0d want 0", ops_done); end
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single_ops();
    test_round_robin();
    test_backpressure();
    test_reset_exec();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
